// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// FreeList
//
// Purpose:
//   Physical-register free list for a two-wide rename/retire pipeline. Free
//   physical registers sit in a circular FIFO. Rename takes up to two
//   registers per cycle from the head. Retire returns up to two registers per
//   cycle at the tail. Allocation is all-or-nothing: if the list cannot
//   satisfy every asserted request, nothing is taken and stall is raised.
//   Registers returned in a cycle become allocatable from the next cycle on.
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rstn            synchronous active-low reset
//   alloc_req_0/1   rename slot 0/1 wants a destination register
//   alloc_preg_0/1  register offered to slot 0/1 (combinational)
//   alloc_grant     every asserted request is satisfied this cycle
//   stall           some request asserted but not granted
//   free_valid_0/1  retire slot 0/1 returns a register
//   free_preg_0/1   register being returned
//   free_count      registers currently held in the list (registered)
//   empty           free_count == 0
//   err_overflow    sticky: a returned register was dropped, list was full
// ---------------------------------------------------------------------------
module free_list #(
    parameter  int NUM_PREG = 64,
    parameter  int NUM_AREG = 32,
    localparam int DEPTH    = NUM_PREG - NUM_AREG,
    localparam int PREG_W   = $clog2(NUM_PREG),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              alloc_req_0,
    input  logic              alloc_req_1,
    output logic [PREG_W-1:0] alloc_preg_0,
    output logic [PREG_W-1:0] alloc_preg_1,
    output logic              alloc_grant,
    output logic              stall,
    input  logic              free_valid_0,
    input  logic              free_valid_1,
    input  logic [PREG_W-1:0] free_preg_0,
    input  logic [PREG_W-1:0] free_preg_1,
    output logic [CNT_W-1:0]  free_count,
    output logic              empty,
    output logic              err_overflow
);

    logic [PREG_W-1:0] listQ [DEPTH];
    logic [PTR_W-1:0]  headQ, headD;
    logic [PTR_W-1:0]  tailQ, tailD;
    logic [CNT_W-1:0]  countQ, countD;
    logic              errQ, errD;

    logic [1:0]        nReq;
    logic [1:0]        nGranted;
    logic [1:0]        nAccepted;
    logic [PTR_W-1:0]  headPlus1;
    logic [PTR_W-1:0]  tailSlot1;
    logic [CNT_W-1:0]  countAfterAlloc;
    logic              freeWant0, freeWant1;
    logic              accept0, accept1;

    // Circular pointer advance by 0..2 entries, wrapping DEPTH-1 -> 0.
    // Written as a compare/subtract so a non-power-of-two depth also wraps.
    function automatic logic [PTR_W-1:0] ptrAdd(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0]       step);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + {{(PTR_W-1){1'b0}}, step};
        if (sum >= (PTR_W+1)'(DEPTH)) begin
            sum = sum - (PTR_W+1)'(DEPTH);
        end
        return sum[PTR_W-1:0];
    endfunction

    // Allocation side. The grant looks only at the registered count, so
    // registers returned this cycle cannot be handed out until next cycle.
    // Slot 1 takes the second entry only when slot 0 is also taking one.
    always_comb begin
        nReq         = {1'b0, alloc_req_0} + {1'b0, alloc_req_1};
        alloc_grant  = (CNT_W'(nReq) <= countQ);
        stall        = (alloc_req_0 | alloc_req_1) & ~alloc_grant;
        nGranted     = alloc_grant ? nReq : 2'd0;
        headPlus1    = ptrAdd(headQ, 2'd1);
        alloc_preg_0 = listQ[headQ];
        alloc_preg_1 = alloc_req_0 ? listQ[headPlus1] : listQ[headQ];
        headD        = ptrAdd(headQ, nGranted);
    end

    // Return side. Register 0 holds the fixed x0 mapping and is never put
    // back. Room is judged after this cycle's grants; slot 0 has priority,
    // so when only one entry is left it is slot 1 that gets dropped.
    always_comb begin
        countAfterAlloc = countQ - CNT_W'(nGranted);
        freeWant0       = free_valid_0 && (free_preg_0 != '0);
        freeWant1       = free_valid_1 && (free_preg_1 != '0);
        accept0         = freeWant0 && (countAfterAlloc < CNT_W'(DEPTH));
        accept1         = freeWant1 &&
                          ((countAfterAlloc + CNT_W'(accept0)) < CNT_W'(DEPTH));
        nAccepted       = {1'b0, accept0} + {1'b0, accept1};
        tailSlot1       = accept0 ? ptrAdd(tailQ, 2'd1) : tailQ;
        tailD           = ptrAdd(tailQ, nAccepted);
        countD          = countAfterAlloc + CNT_W'(nAccepted);
        errD            = errQ | (freeWant0 & ~accept0) | (freeWant1 & ~accept1);
    end

    // State update. Reset reloads the list with every non-architectural
    // register in ascending order and ignores all requests that cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                listQ[i] <= PREG_W'(NUM_AREG + i);
            end
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= CNT_W'(DEPTH);
            errQ   <= 1'b0;
        end else begin
            if (accept0) begin
                listQ[tailQ] <= free_preg_0;
            end
            if (accept1) begin
                listQ[tailSlot1] <= free_preg_1;
            end
            headQ  <= headD;
            tailQ  <= tailD;
            countQ <= countD;
            errQ   <= errD;
        end
    end

    assign free_count   = countQ;
    assign empty        = (countQ == '0);
    assign err_overflow = errQ;

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// TbFreeList
//
// Purpose:
//   Directed self-checking bench for free_list. Inputs change 1 time unit
//   after a rising edge; combinational outputs are checked once they settle,
//   registered outputs 1 time unit after the following edge.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_free_list;

    logic       clk;
    logic       rstn;
    logic       allocReq0, allocReq1;
    logic [5:0] allocPreg0, allocPreg1;
    logic       allocGrant, stall;
    logic       freeValid0, freeValid1;
    logic [5:0] freePreg0, freePreg1;
    logic [5:0] freeCount;
    logic       empty;
    logic       errOverflow;

    int checks = 0;
    int passes = 0;

    logic [5:0] model [$];
    logic [5:0] a, b;

    free_list #(
        .NUM_PREG(64),
        .NUM_AREG(32)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .alloc_req_0  (allocReq0),
        .alloc_req_1  (allocReq1),
        .alloc_preg_0 (allocPreg0),
        .alloc_preg_1 (allocPreg1),
        .alloc_grant  (allocGrant),
        .stall        (stall),
        .free_valid_0 (freeValid0),
        .free_valid_1 (freeValid1),
        .free_preg_0  (freePreg0),
        .free_preg_1  (freePreg1),
        .free_count   (freeCount),
        .empty        (empty),
        .err_overflow (errOverflow)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's worth of inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic fv0, input logic [5:0] fp0,
                                 input logic fv1, input logic [5:0] fp1);
        allocReq0  = r0;
        allocReq1  = r1;
        freeValid0 = fv0;
        freePreg0  = fp0;
        freeValid1 = fv1;
        freePreg1  = fp1;
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            passes++;
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        rstn = 1'b0;
        applyStimulus(1, 1, 1, 6'd9, 1, 6'd10);
        tick();
        tick();
        rstn = 1'b1;

        // Reset state.
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_count", freeCount, 32);
        checkOutput("rst_empty", empty, 0);
        checkOutput("rst_err", errOverflow, 0);
        checkOutput("idle_grant", allocGrant, 1);
        checkOutput("idle_stall", stall, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("rst_p0", allocPreg0, 32);
        checkOutput("rst_p1", allocPreg1, 33);
        checkOutput("rst_stall", stall, 0);

        // Drain the whole list with dual allocations.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            checkOutput("drain_p0", allocPreg0, 32 + 2 * k);
            checkOutput("drain_p1", allocPreg1, 33 + 2 * k);
            checkOutput("drain_grant", allocGrant, 1);
            tick();
            checkOutput("drain_count", freeCount, 32 - 2 * (k + 1));
        end
        checkOutput("drain_empty", empty, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("empty_stall", stall, 1);
        checkOutput("empty_grant", allocGrant, 0);

        // Free p5 and p7 while empty; same-cycle request must still stall.
        applyStimulus(1, 0, 1, 6'd5, 1, 6'd7);
        checkOutput("free_same_cycle_stall", stall, 1);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("free2_count", freeCount, 2);
        checkOutput("free2_empty", empty, 0);
        checkOutput("free2_p0", allocPreg0, 5);
        checkOutput("free2_p1", allocPreg1, 7);

        // Bring count to 1, then a dual request must stall without effect.
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("one_count", freeCount, 1);
        checkOutput("one_stall", stall, 1);
        checkOutput("one_grant", allocGrant, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("stall_hold_count", freeCount, 1);
        checkOutput("slot1_grant", allocGrant, 1);
        checkOutput("slot1_stall", stall, 0);
        checkOutput("slot1_p1", allocPreg1, 7);
        tick();
        checkOutput("slot1_count", freeCount, 0);

        // p0 is never recycled; p9 in slot 1 lands where slot 0 would have.
        applyStimulus(0, 0, 1, 6'd0, 1, 6'd9);
        tick();
        checkOutput("p0_pair_count", freeCount, 1);
        applyStimulus(0, 0, 1, 6'd0, 0, 0);
        tick();
        checkOutput("p0_only_count", freeCount, 1);
        checkOutput("p0_err", errOverflow, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("p0_skip_p0", allocPreg0, 9);
        tick();

        // Count 4, then dual alloc plus dual free in the same cycle.
        applyStimulus(0, 0, 1, 6'd10, 1, 6'd11);
        tick();
        applyStimulus(0, 0, 1, 6'd12, 1, 6'd13);
        tick();
        checkOutput("four_count", freeCount, 4);
        applyStimulus(1, 1, 1, 6'd20, 1, 6'd21);
        checkOutput("mix_p0", allocPreg0, 10);
        checkOutput("mix_p1", allocPreg1, 11);
        checkOutput("mix_grant", allocGrant, 1);
        tick();
        checkOutput("mix_count", freeCount, 4);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("mix_next_p0", allocPreg0, 12);
        checkOutput("mix_next_p1", allocPreg1, 13);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("mix_late_p0", allocPreg0, 20);
        checkOutput("mix_late_p1", allocPreg1, 21);
        tick();
        checkOutput("mix_drain_count", freeCount, 0);

        // Fill to 31, then a dual free keeps slot 0 and drops slot 1.
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 1, 6'(32 + 2 * k), 1, 6'(33 + 2 * k));
            tick();
            checkOutput("fill_count", freeCount, 2 * (k + 1));
        end
        applyStimulus(0, 0, 1, 6'd62, 0, 0);
        tick();
        checkOutput("fill31_count", freeCount, 31);
        checkOutput("fill31_err", errOverflow, 0);
        applyStimulus(0, 0, 1, 6'd63, 1, 6'd40);
        tick();
        checkOutput("slot1_drop_count", freeCount, 32);
        checkOutput("slot1_drop_err", errOverflow, 1);
        applyStimulus(0, 0, 1, 6'd40, 0, 0);
        tick();
        checkOutput("full_drop_count", freeCount, 32);
        checkOutput("full_drop_err", errOverflow, 1);

        // Drain: exactly p32..p63 in order, the dropped p40 never appears.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            checkOutput("refill_p0", allocPreg0, 32 + 2 * k);
            checkOutput("refill_p1", allocPreg1, 33 + 2 * k);
            tick();
            checkOutput("err_sticky", errOverflow, 1);
        end
        checkOutput("refill_empty", empty, 1);

        // Pointer wrap: 40 cycles of dual alloc returning the same pair
        // swapped, compared against a queue model of the FIFO order.
        for (int k = 1; k <= 6; k += 2) begin
            applyStimulus(0, 0, 1, 6'(k), 1, 6'(k + 1));
            tick();
            model.push_back(6'(k));
            model.push_back(6'(k + 1));
        end
        for (int k = 0; k < 40; k++) begin
            a = model[0];
            b = model[1];
            applyStimulus(1, 1, 1, b, 1, a);
            checkOutput("wrap_p0", allocPreg0, a);
            checkOutput("wrap_p1", allocPreg1, b);
            tick();
            void'(model.pop_front());
            void'(model.pop_front());
            model.push_back(b);
            model.push_back(a);
            checkOutput("wrap_count", freeCount, 6);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            checkOutput("wrap_drain_p0", allocPreg0, model[0]);
            checkOutput("wrap_drain_p1", allocPreg1, model[1]);
            tick();
            void'(model.pop_front());
            void'(model.pop_front());
        end
        checkOutput("wrap_empty", empty, 1);
        checkOutput("pre_reset_err", errOverflow, 1);

        // Reset mid-operation discards pending activity.
        rstn = 1'b0;
        applyStimulus(1, 1, 1, 6'd8, 1, 6'd9);
        tick();
        rstn = 1'b1;
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("rst2_count", freeCount, 32);
        checkOutput("rst2_err", errOverflow, 0);
        checkOutput("rst2_empty", empty, 0);
        checkOutput("rst2_p0", allocPreg0, 32);
        checkOutput("rst2_p1", allocPreg1, 33);
        checkOutput("rst2_stall", stall, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_PREG, default 64, number of physical registers.
REQ-002 SHALL have parameter NUM_AREG, default 32, number of architectural registers; list depth DEPTH = NUM_PREG - NUM_AREG = 32.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset; synchronous, active-low.
REQ-005 SHALL have ports alloc_req_0, alloc_req_1  input  1  rename slot 0/1 requests a destination physical register.
REQ-006 SHALL have ports alloc_preg_0, alloc_preg_1  output  6  physical register offered to slot 0/1 (combinational).
REQ-007 SHALL have port alloc_grant  output  1  all asserted requests are satisfied this cycle (combinational).
REQ-008 SHALL have port stall  output  1  requests exceed free registers (combinational); equals any request AND NOT alloc_grant.
REQ-009 SHALL have ports free_valid_0, free_valid_1  input  1  retire slot 0/1 returns an old destination register.
REQ-010 SHALL have ports free_preg_0, free_preg_1  input  6  physical register being returned.
REQ-011 SHALL have port free_count  output  6  number of registers currently in the list (registered).
REQ-012 SHALL have port empty  output  1  free_count == 0.
REQ-013 SHALL have port err_overflow  output  1  sticky flag: a free was dropped because the list was full.

Function
REQ-014 SHALL store free registers in a circular FIFO of DEPTH 6-bit entries with 5-bit head (read) and tail (write) pointers; pointers wrap DEPTH-1 -> 0.
REQ-015 SHALL compute nreq = alloc_req_0 + alloc_req_1; alloc_grant = 1 iff nreq <= free_count; with nreq = 0, alloc_grant = 1 and stall = 0.
REQ-016 SHALL drive alloc_preg_0 = list[head]; alloc_preg_1 = list[head+1] if alloc_req_0, else list[head]; values are don't-care when not granted.
REQ-017 SHALL be all-or-nothing: on grant head advances by nreq at the edge; on stall head and list are unchanged (no partial allocation).
REQ-018 SHALL ignore a free whose preg is 0 (x0 mapping is never recycled); a valid free of preg 0 contributes nothing.
REQ-019 SHALL write accepted frees at tail in slot order (slot 0 then slot 1) and advance tail by the number written.
REQ-020 SHALL not make registers freed in cycle N allocatable before cycle N+1 (grant uses registered free_count only).
REQ-021 SHALL, with simultaneous alloc and free, update free_count_next = free_count - granted + accepted frees; result never exceeds DEPTH.
REQ-022 SHALL drop any free that would push the count beyond DEPTH (after that cycle's grants), dropping slot 1 before slot 0, and set err_overflow.
REQ-023 SHALL never allocate preg 0 and never allocate a register while free_count == 0.

Reset
REQ-024 SHALL, when rstn = 0 at a rising edge, set list[i] = NUM_AREG + i for i = 0..DEPTH-1, head = 0, tail = 0, free_count = DEPTH, err_overflow = 0; inputs are ignored that cycle.
REQ-025 SHALL, after reset, present alloc_preg_0 = 32, alloc_preg_1 = 33 (both requested), empty = 0, stall = 0.
REQ-026 SHALL, on reset asserted mid-operation, discard all pending allocations and frees and return to the REQ-024 state.

Verification
REQ-027 SHALL be verified: reset, then dual alloc for 16 cycles -> grants p32..p63 in order, free_count 32 -> 0, empty = 1.
REQ-028 SHALL be verified: free_count = 1, alloc_req_0 = alloc_req_1 = 1 -> stall = 1, alloc_grant = 0, head and free_count unchanged; single alloc_req_1 next cycle -> granted, alloc_preg_1 = list[head].
REQ-029 SHALL be verified: empty list, free p5 and p7 in one cycle -> next cycle free_count = 2, alloc_preg_0 = 5, alloc_preg_1 = 7.
REQ-030 SHALL be verified: free_count = 4, dual alloc plus dual free same cycle -> free_count stays 4, freed registers appear after the remaining two in FIFO order.
REQ-031 SHALL be verified: full list (32), free p40 -> dropped, free_count = 32, err_overflow = 1 and stays 1 until reset; free p0 on non-full list -> ignored, count unchanged.
REQ-032 SHALL be verified: pointer wrap after 40 alloc/free pairs -> FIFO order preserved across index 31 -> 0, no register duplicated or lost (multiset of list contents constant).
